// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/operand/result bundle for the bit-serial adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             iSTART;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oBUSY;
    logic             oDONE;
    logic [WIDTH-1:0] oSUM;
    logic             oCARRY;

    modport master (
        output iSTART, iA, iB,
        input  oBUSY, oDONE, oSUM, oCARRY
    );

    modport slave (
        input  iSTART, iA, iB,
        output oBUSY, oDONE, oSUM, oCARRY
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built from two half_adder cells
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic         iCLK,
    input  logic         iRST,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT            state;
    logic [WIDTH-1:0] aSh;
    logic [WIDTH-1:0] bSh;
    logic [WIDTH-1:0] sumSh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busyR;
    logic             doneR;
    logic [WIDTH-1:0] sumR;
    logic             carryR;

    logic             halfSum;
    logic             genCarry;
    logic             bitSum;
    logic             propCarry;
    logic             carryNext;
    logic [WIDTH-1:0] sumNext;
    logic             lastBit;

    half_adder haLow (
        .a (aSh[0]),
        .b (bSh[0]),
        .s (halfSum),
        .c (genCarry)
    );

    half_adder haCarry (
        .a (halfSum),
        .b (carry),
        .s (bitSum),
        .c (propCarry)
    );

    assign carryNext = genCarry | propCarry;
    // New bit enters at the MSB; after WIDTH shifts bit 0 of the operands sits at bit 0.
    assign sumNext   = WIDTH'({bitSum, sumSh} >> 1);
    assign lastBit   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= IDLE;
            aSh    <= '0;
            bSh    <= '0;
            sumSh  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busyR  <= 1'b0;
            doneR  <= 1'b0;
            sumR   <= '0;
            carryR <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    doneR <= 1'b0;
                    if (bus.iSTART) begin
                        aSh   <= bus.iA;
                        bSh   <= bus.iB;
                        sumSh <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busyR <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    aSh   <= aSh >> 1;
                    bSh   <= bSh >> 1;
                    sumSh <= sumNext;
                    carry <= carryNext;
                    cnt   <= cnt + CW'(1);
                    if (lastBit) begin
                        sumR   <= sumNext;
                        carryR <= carryNext;
                        doneR  <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    doneR <= 1'b0;
                    busyR <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    doneR <= 1'b0;
                    busyR <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oBUSY  = busyR;
    assign bus.oDONE  = doneR;
    assign bus.oSUM   = sumR;
    assign bus.oCARRY = carryR;
endmodule
